// File: rtl/stage2_fmap_window_gen.sv
// stage2_fmap_window_gen
//   Builds the KXxKY convolution window for the stage-2 kernel array from a
//   raster-order feature-map stream (one pixel per valid cycle, no backpressure).
//   Ports:
//     clk, reset     : rising-edge clock, synchronous active-high reset
//     i_in_valid     : i_in_pixel is valid this cycle
//     i_in_pixel     : signed pixel, row-major raster order
//     o_ot_valid     : o_ot_fmap holds a complete window this cycle
//     o_ot_fmap      : window, element ky*KX+kx at [(ky*KX+kx)*IBW +: IBW]
//     o_frame_done   : pulses with the last window of a frame
//     o_busy         : high while a frame is partially received
module stage2_fmap_window_gen #(
  parameter int unsigned IMG_W = 12,
  parameter int unsigned IMG_H = 12,
  parameter int unsigned KX    = 5,
  parameter int unsigned KY    = 5,
  parameter int unsigned IBW   = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_in_valid,
  input  logic [IBW-1:0]         i_in_pixel,
  output logic                   o_ot_valid,
  output logic [KX*KY*IBW-1:0]   o_ot_fmap,
  output logic                   o_frame_done,
  output logic                   o_busy
);

  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned FMAP_W = KX * KY * IBW;

  localparam logic [COL_W-1:0] COL_LAST      = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(IMG_H - 1);
  localparam logic [ROW_W-1:0] ROW_FILL_LAST = ROW_W'(KY - 2);
  localparam logic [COL_W-1:0] COL_WIN_MIN   = COL_W'(KX - 1);
  localparam logic [ROW_W-1:0] ROW_WIN_MIN   = ROW_W'(KY - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [COL_W-1:0]    r_col;
  logic [ROW_W-1:0]    r_row;

  // r_line[KY-2] holds row r-1, r_line[0] holds row r-KY+1 (oldest)
  logic [IBW-1:0]      r_line [KY-1][IMG_W];
  logic [IBW-1:0]      r_win  [KY][KX];
  logic [IBW-1:0]      w_win_nxt [KY][KX];
  logic [FMAP_W-1:0]   w_fmap_nxt;

  logic w_col_last;
  logic w_row_last;
  logic w_frame_last;
  logic w_fill_last;
  logic w_win_ok;

  assign w_col_last   = (r_col == COL_LAST);
  assign w_row_last   = (r_row == ROW_LAST);
  assign w_frame_last = w_col_last && w_row_last;
  assign w_fill_last  = w_col_last && (r_row == ROW_FILL_LAST);
  assign w_win_ok     = (r_row >= ROW_WIN_MIN) && (r_col >= COL_WIN_MIN);

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (i_in_valid) begin
      case (r_state)
        S_IDLE:   w_state_nxt = S_FILL;
        S_FILL:   if (w_fill_last)  w_state_nxt = S_STREAM;
        S_STREAM: if (w_frame_last) w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Window after shifting in the new column (line-buffer taps + incoming pixel)
  always_comb begin
    w_win_nxt  = '{default: '0};
    w_fmap_nxt = '0;
    for (int ky = 0; ky < KY; ky++) begin
      for (int kx = 0; kx < KX - 1; kx++) begin
        w_win_nxt[ky][kx] = r_win[ky][kx+1];
      end
      if (ky == KY - 1) w_win_nxt[ky][KX-1] = i_in_pixel;
      else              w_win_nxt[ky][KX-1] = r_line[ky][r_col];
    end
    for (int ky = 0; ky < KY; ky++) begin
      for (int kx = 0; kx < KX; kx++) begin
        w_fmap_nxt[(ky*KX+kx)*IBW +: IBW] = w_win_nxt[ky][kx];
      end
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_col        <= '0;
      r_row        <= '0;
      o_ot_valid   <= 1'b0;
      o_frame_done <= 1'b0;
      o_busy       <= 1'b0;
      o_ot_fmap    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      o_busy       <= (w_state_nxt != S_IDLE);
      o_ot_valid   <= i_in_valid && w_win_ok;
      o_frame_done <= i_in_valid && w_frame_last;
      if (i_in_valid) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
        if (w_win_ok) o_ot_fmap <= w_fmap_nxt;
      end
    end
  end

  // Data storage; never cleared since only fully refreshed windows are emitted
  always_ff @(posedge clk) begin
    if (!reset && i_in_valid) begin
      for (int ky = 0; ky < KY; ky++) begin
        for (int kx = 0; kx < KX; kx++) begin
          r_win[ky][kx] <= w_win_nxt[ky][kx];
        end
      end
      for (int ky = 0; ky < KY - 2; ky++) begin
        r_line[ky][r_col] <= r_line[ky+1][r_col];
      end
      r_line[KY-2][r_col] <= i_in_pixel;
    end
  end

endmodule

// File: tb/tb_stage2_fmap_window_gen.sv
// Testbench for stage2_fmap_window_gen: directed frames with a scoreboard of
// expected windows built from a per-frame image model.
module tb_stage2_fmap_window_gen;

  localparam int IMG_W = 12;
  localparam int IMG_H = 12;
  localparam int KX    = 5;
  localparam int KY    = 5;
  localparam int IBW   = 20;
  localparam int FW    = KX * KY * IBW;
  localparam int NPIX  = IMG_W * IMG_H;

  logic            clk;
  logic            reset;
  logic            i_in_valid;
  logic [IBW-1:0]  i_in_pixel;
  logic            o_ot_valid;
  logic [FW-1:0]   o_ot_fmap;
  logic            o_frame_done;
  logic            o_busy;

  stage2_fmap_window_gen dut (
    .clk          (clk),
    .reset        (reset),
    .i_in_valid   (i_in_valid),
    .i_in_pixel   (i_in_pixel),
    .o_ot_valid   (o_ot_valid),
    .o_ot_fmap    (o_ot_fmap),
    .o_frame_done (o_frame_done),
    .o_busy       (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [FW-1:0] fmap;
    logic          done;
  } exp_t;

  exp_t           q[$];
  logic [IBW-1:0] img [IMG_H][IMG_W];
  int             mr;
  int             mc;
  int             checks;
  int             failures;
  int             win_cnt;
  int             done_cnt;

  function automatic logic [IBW-1:0] el(input logic [FW-1:0] f, input int i);
    return f[i*IBW +: IBW];
  endfunction

  function automatic logic [IBW-1:0] ramp(input int r, input int c, input logic [IBW-1:0] off);
    return IBW'((r << 4) | c) + off;
  endfunction

  // Independent window built directly from the ramp formula
  function automatic logic [FW-1:0] ramp_win(input int r, input int c, input logic [IBW-1:0] off);
    logic [FW-1:0] w;
    w = '0;
    for (int ky = 0; ky < KY; ky++)
      for (int kx = 0; kx < KX; kx++)
        w[(ky*KX+kx)*IBW +: IBW] = ramp(r-KY+1+ky, c-KX+1+kx, off);
    return w;
  endfunction

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: model/scoreboard update at accept, output check next half cycle
  task automatic drive(input logic v, input logic rst, input logic [IBW-1:0] p);
    exp_t e;
    logic exp_v;
    i_in_valid = v;
    reset      = rst;
    i_in_pixel = p;
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
    reset      = 1'b0;
    if (rst) begin
      mr = 0;
      mc = 0;
    end else if (v) begin
      img[mr][mc] = p;
      if (mr >= KY-1 && mc >= KX-1) begin
        e.fmap = '0;
        for (int ky = 0; ky < KY; ky++)
          for (int kx = 0; kx < KX; kx++)
            e.fmap[(ky*KX+kx)*IBW +: IBW] = img[mr-KY+1+ky][mc-KX+1+kx];
        e.done = (mr == IMG_H-1) && (mc == IMG_W-1);
        q.push_back(e);
      end
      mc++;
      if (mc == IMG_W) begin
        mc = 0;
        mr++;
        if (mr == IMG_H) mr = 0;
      end
    end
    @(negedge clk);
    exp_v = (q.size() != 0);
    chk("valid", FW'(o_ot_valid), FW'(exp_v));
    if (exp_v) begin
      e = q.pop_front();
      chk("window", o_ot_fmap, e.fmap);
      chk("frame_done", FW'(o_frame_done), FW'(e.done));
      if (o_ot_valid) win_cnt++;
      if (o_frame_done) done_cnt++;
    end else begin
      chk("frame_done_idle", FW'(o_frame_done), FW'(1'b0));
    end
  endtask

  // Sends pixels 0..npix-1 of a ramp frame; gap idle cycles after each pixel
  task automatic send_frame(input logic [IBW-1:0] off, input int gap, input int npix, input bit special);
    logic [IBW-1:0] px;
    int r;
    int c;
    for (int idx = 0; idx < npix; idx++) begin
      r  = idx / IMG_W;
      c  = idx % IMG_W;
      px = ramp(r, c, off);
      if (special && r == 4 && c == 4) px = 20'h80000;
      if (special && r == 4 && c == 5) px = 20'h7FFFF;
      drive(1'b1, 1'b0, px);
      if (idx == 0) chk("busy_start", FW'(o_busy), FW'(1'b1));
      if (r == KY-1 && c == KX-1) begin
        if (special) begin
          chk("signed_min_el24", FW'(el(o_ot_fmap, 24)), FW'(20'h80000));
        end else begin
          chk("first_win", o_ot_fmap, ramp_win(r, c, off));
          chk("first_el0",  FW'(el(o_ot_fmap, 0)),  FW'(off + 20'h00));
          chk("first_el12", FW'(el(o_ot_fmap, 12)), FW'(off + 20'h22));
          chk("first_el24", FW'(el(o_ot_fmap, 24)), FW'(off + 20'h44));
        end
      end
      if (special && r == 4 && c == 5) begin
        chk("signed_max_el24", FW'(el(o_ot_fmap, 24)), FW'(20'h7FFFF));
        chk("signed_min_el23", FW'(el(o_ot_fmap, 23)), FW'(20'h80000));
      end
      if (!special && idx == NPIX-1) begin
        chk("last_done", FW'(o_frame_done), FW'(1'b1));
        chk("last_el24", FW'(el(o_ot_fmap, 24)), FW'(off + 20'hBB));
        chk("last_win", o_ot_fmap, ramp_win(r, c, off));
        chk("busy_end", FW'(o_busy), FW'(1'b0));
      end
      for (int g = 0; g < gap; g++) drive(1'b0, 1'b0, '0);
    end
  endtask

  task automatic chk_counts(input string tag, input int wbase, input int dbase, input int nwin, input int ndone);
    chk({tag, "_windows"}, FW'(win_cnt - wbase), FW'(nwin));
    chk({tag, "_frames"},  FW'(done_cnt - dbase), FW'(ndone));
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, FW'(o_ot_valid), FW'(1'b0));
    chk({tag, "_done"},  FW'(o_frame_done), FW'(1'b0));
    chk({tag, "_busy"},  FW'(o_busy), FW'(1'b0));
  endtask

  initial begin
    int wb;
    int db;
    checks     = 0;
    failures   = 0;
    win_cnt    = 0;
    done_cnt   = 0;
    mr         = 0;
    mc         = 0;
    reset      = 1'b1;
    i_in_valid = 1'b0;
    i_in_pixel = '0;

    // Reset state
    drive(1'b0, 1'b1, '0);
    drive(1'b0, 1'b1, '0);
    chk_idle_outputs("reset");
    chk("reset_fmap", o_ot_fmap, '0);

    // 1: gapless ramp frame
    wb = win_cnt; db = done_cnt;
    send_frame('0, 0, NPIX, 1'b0);
    chk_counts("t1", wb, db, 64, 1);

    // 2: same ramp with two idle cycles after every pixel
    wb = win_cnt; db = done_cnt;
    send_frame('0, 2, NPIX, 1'b0);
    chk_counts("t2", wb, db, 64, 1);

    // 3: back-to-back frames, second offset by 0x100
    wb = win_cnt; db = done_cnt;
    send_frame('0, 0, NPIX, 1'b0);
    send_frame(20'h100, 0, NPIX, 1'b0);
    chk_counts("t3", wb, db, 128, 2);

    // 4: reset after accepting (6,3), then a fresh frame
    send_frame('0, 0, 6*IMG_W + 3 + 1, 1'b0);
    chk("t4_busy_mid", FW'(o_busy), FW'(1'b1));
    drive(1'b0, 1'b1, '0);
    chk_idle_outputs("t4_reset");
    chk("t4_reset_fmap", o_ot_fmap, '0);
    wb = win_cnt; db = done_cnt;
    send_frame('0, 0, NPIX, 1'b0);
    chk_counts("t4", wb, db, 64, 1);

    // 5: signed extremes at (4,4) and (4,5)
    wb = win_cnt; db = done_cnt;
    send_frame('0, 0, NPIX, 1'b1);
    chk_counts("t5", wb, db, 64, 1);

    // 6: reset together with a window-completing pixel at (5,6)
    send_frame('0, 0, 5*IMG_W + 5 + 1, 1'b0);
    drive(1'b1, 1'b1, 20'h12345);
    chk_idle_outputs("t6_reset_valid");
    wb = win_cnt; db = done_cnt;
    send_frame('0, 0, NPIX, 1'b0);
    chk_counts("t6", wb, db, 64, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
